// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - SCAN (collective) elevator controller with latched hall/cab calls
// Serves every call ahead in the travel direction, then reverses; door dwell restarts on same-floor presses.
module elevator_scan_ctrl #(
    parameter int  FLOORS      = 4,
    parameter int  MOVE_CYCLES = 2,
    parameter int  DOOR_CYCLES = 3,
    localparam int POS_W       = $clog2(2*FLOORS-1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-2:0] button_up,
    input  logic [FLOORS-2:0] button_down,
    input  logic [FLOORS-1:0] button_in,
    output logic [POS_W-1:0]  position,
    output logic              open,
    output logic [1:0]        direction,
    output logic [FLOORS-2:0] pend_up,
    output logic [FLOORS-2:0] pend_down,
    output logic [FLOORS-1:0] pend_in
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UP     = 2'd1;
    localparam logic [1:0] S_DOWN   = 2'd2;
    localparam logic [1:0] S_DOOR   = 2'd3;
    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_TOP   = POS_W'(2*(FLOORS-1));

    logic [1:0]        state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [1:0]        dir_q, dir_d;
    logic              open_q, open_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FLOORS-2:0] pu_q, pu_d, pd_q, pd_d;
    logic [FLOORS-1:0] pi_q, pi_d;

    // Hall calls are remapped to per-floor vectors so floor f always means bit f.
    logic [FLOORS-1:0] here_f, req_up_f, req_dn_f, req_all_f, btn_up_f, btn_dn_f;
    logic [FLOORS-1:0] abs_in_f, abs_up_f, abs_dn_f, clr_in_f, clr_up_f, clr_dn_f;
    logic              any_above, any_below, here_in, here_up, here_dn, here_any;
    logic              door_hold, going_up, ahead, at_floor, stop;
    int                cur_floor;

    always_comb begin
        cur_floor = int'(pos_q >> 1);
        req_up_f  = '0;
        req_dn_f  = '0;
        btn_up_f  = '0;
        btn_dn_f  = '0;
        here_f    = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < FLOORS-1; i++) begin
            req_up_f[i]   = pu_q[i];
            req_dn_f[i+1] = pd_q[i];
            btn_up_f[i]   = button_up[i];
            btn_dn_f[i+1] = button_down[i];
        end
        req_all_f = pi_q | req_up_f | req_dn_f;
        for (int i = 0; i < FLOORS; i++) begin
            here_f[i] = (i == cur_floor);
            if (i > cur_floor) any_above = any_above | req_all_f[i];
            if (i < cur_floor) any_below = any_below | req_all_f[i];
        end
        here_in  = |(pi_q & here_f);
        here_up  = |(req_up_f & here_f);
        here_dn  = |(req_dn_f & here_f);
        here_any = here_in | here_up | here_dn;
        // Presses absorbed by an open door: cab at f, hall at f matching travel direction.
        abs_in_f  = open_q ? here_f : '0;
        abs_up_f  = (open_q && dir_q != DIR_DOWN) ? here_f : '0;
        abs_dn_f  = (open_q && dir_q != DIR_UP) ? here_f : '0;
        door_hold = |((button_in & abs_in_f) | (btn_up_f & abs_up_f) | (btn_dn_f & abs_dn_f));
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        open_d   = open_q;
        cnt_d    = cnt_q;
        clr_in_f = '0;
        clr_up_f = '0;
        clr_dn_f = '0;
        going_up = (state_q == S_UP);
        ahead    = going_up ? any_above : any_below;
        at_floor = !pos_q[0] && (cnt_q == '0);
        stop     = here_in | (going_up ? here_up : here_dn) | (!ahead & (going_up ? here_dn : here_up));

        case (state_q)
            S_IDLE: begin
                dir_d = DIR_STOP;
                if (here_any) begin
                    state_d  = S_DOOR;
                    open_d   = 1'b1;
                    cnt_d    = DOOR_LOAD;
                    clr_in_f = here_f;
                    clr_up_f = here_f;
                    clr_dn_f = here_f;
                end else if (any_above) begin
                    state_d = S_UP;
                    dir_d   = DIR_UP;
                    cnt_d   = '0;
                end else if (any_below) begin
                    state_d = S_DOWN;
                    dir_d   = DIR_DOWN;
                    cnt_d   = '0;
                end
            end
            S_UP, S_DOWN: begin
                if (at_floor && stop) begin
                    state_d  = S_DOOR;
                    open_d   = 1'b1;
                    cnt_d    = DOOR_LOAD;
                    clr_in_f = here_f;
                    if (going_up || !ahead) clr_up_f = here_f;
                    if (!going_up || !ahead) clr_dn_f = here_f;
                end else if (at_floor && !ahead) begin
                    state_d = S_IDLE;
                    dir_d   = DIR_STOP;
                end else if (cnt_q == MOVE_LAST) begin
                    cnt_d = '0;
                    if (going_up && pos_q != POS_TOP) pos_d = pos_q + 1'b1;
                    else if (!going_up && pos_q != '0) pos_d = pos_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (door_hold) begin
                    cnt_d = DOOR_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    open_d = 1'b0;
                    cnt_d  = '0;
                    if (dir_q == DIR_UP && any_above) begin
                        state_d = S_UP;
                    end else if (dir_q == DIR_DOWN && any_below) begin
                        state_d = S_DOWN;
                    end else if (here_any) begin
                        // A call latched at this floor while open: close, then IDLE reopens for it.
                        state_d = S_IDLE;
                        dir_d   = DIR_STOP;
                    end else if (any_above) begin
                        state_d = S_UP;
                        dir_d   = DIR_UP;
                    end else if (any_below) begin
                        state_d = S_DOWN;
                        dir_d   = DIR_DOWN;
                    end else begin
                        state_d = S_IDLE;
                        dir_d   = DIR_STOP;
                    end
                end
            end
        endcase

        pi_d = (pi_q | (button_in & ~abs_in_f)) & ~clr_in_f;
        pu_d = '0;
        pd_d = '0;
        for (int i = 0; i < FLOORS-1; i++) begin
            pu_d[i] = (pu_q[i] | (button_up[i] & ~abs_up_f[i])) & ~clr_up_f[i];
            pd_d[i] = (pd_q[i] | (button_down[i] & ~abs_dn_f[i+1])) & ~clr_dn_f[i+1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pos_q   <= '0;
            dir_q   <= DIR_STOP;
            open_q  <= 1'b0;
            cnt_q   <= '0;
            pu_q    <= '0;
            pd_q    <= '0;
            pi_q    <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            open_q  <= open_d;
            cnt_q   <= cnt_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
            pi_q    <= pi_d;
        end
    end

    assign position  = pos_q;
    assign open      = open_q;
    assign direction = dir_q;
    assign pend_up   = pu_q;
    assign pend_down = pd_q;
    assign pend_in   = pi_q;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - scoreboard bench for elevator_scan_ctrl (FLOORS=4, MOVE=2, DOOR=3)
// Snapshot = {position, open, direction, pend_in, pend_up, pend_down}; every change must match the queue head.
module tb_elevator_scan_ctrl;
    logic       clk;
    logic       reset;
    logic [2:0] button_up, button_down;
    logic [3:0] button_in;
    logic [2:0] position;
    logic       open;
    logic [1:0] direction;
    logic [2:0] pend_up, pend_down;
    logic [3:0] pend_in;

    elevator_scan_ctrl #(.FLOORS(4), .MOVE_CYCLES(2), .DOOR_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .button_up(button_up), .button_down(button_down), .button_in(button_in),
        .position(position), .open(open), .direction(direction),
        .pend_up(pend_up), .pend_down(pend_down), .pend_in(pend_in)
    );

    typedef struct {
        int          cyc;
        logic [15:0] v;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          base = 0;
    int          rel;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic        chk_end = 1'b0;
    logic [15:0] prev = '0;
    logic [15:0] cur;

    logic [2:0] m_pos;
    logic       m_open;
    logic [1:0] m_dir;
    logic [3:0] m_pin;
    logic [2:0] m_pup, m_pdn;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            rel = cyc - base;
            cur = {position, open, direction, pend_in, pend_up, pend_down};
            if (cur !== prev || (sb.size() > 0 && sb[0].cyc == rel)) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change: edge %0d got %h, required unchanged %h", rel, cur, prev);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || cur !== e.v) begin
                        n_fail++;
                        $display("FAIL %s: edge %0d got %h, required %h at edge %0d", e.name, rel, cur, e.v, e.cyc);
                    end
                end
            end
            prev = cur;
            if (chk_end) begin
                n_checks++;
                if (sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL leftover: %0d expected events never seen, required 0", sb.size());
                    sb.delete();
                end
            end
        end
    end

    task automatic ev(input int c, input string nm);
        sb.push_back('{cyc: c, v: {m_pos, m_open, m_dir, m_pin, m_pup, m_pdn}, name: nm});
    endtask

    task automatic wait_edge(input int n);
        while (cyc - base < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_test(input logic hold_buttons);
        mon_en      = 1'b0;
        reset       = 1'b1;
        button_in   = hold_buttons ? 4'hF : 4'h0;
        button_up   = hold_buttons ? 3'h7 : 3'h0;
        button_down = hold_buttons ? 3'h7 : 3'h0;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        button_in   = '0;
        button_up   = '0;
        button_down = '0;
        base        = cyc;
        {m_pos, m_open, m_dir, m_pin, m_pup, m_pdn} = '0;
        prev        = '0;
        ev(0, "reset_state");
        mon_en      = 1'b1;
    endtask

    task automatic end_test(input int n);
        wait_edge(n);
        chk_end = 1'b1;
        @(negedge clk);
        #1;
        chk_end = 1'b0;
    endtask

    task automatic press(input int k, input logic [3:0] cab, input logic [2:0] up, input logic [2:0] dn);
        wait_edge(k - 1);
        button_in   = cab;
        button_up   = up;
        button_down = dn;
        wait_edge(k);
        button_in   = '0;
        button_up   = '0;
        button_down = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        button_in = '0; button_up = '0; button_down = '0;

        // T1: buttons held during reset must not latch
        start_test(1'b1);
        ev(3, "t1_hold");
        end_test(4);

        // T2: cab call to floor 2 from idle at 0
        start_test(1'b0);
        m_pin = 4'b0100; ev(1, "t2_latch");
        m_dir = 2'b01;   ev(2, "t2_dir_up");
        for (int k = 1; k <= 4; k++) begin m_pos = 3'(k); ev(2 + 2*k, "t2_pos"); end
        m_open = 1'b1; m_pin = 4'b0000; ev(11, "t2_open");
        ev(13, "t2_dwell");
        m_open = 1'b0; m_dir = 2'b00; ev(14, "t2_close");
        press(1, 4'b0100, 3'b000, 3'b000);
        end_test(18);

        // T3: pass floor 1 (down call) going up, serve 3, reverse, stop at 1
        start_test(1'b0);
        m_pin = 4'b1000; m_pdn = 3'b001; ev(1, "t3_latch");
        m_dir = 2'b01; ev(2, "t3_dir_up");
        for (int k = 1; k <= 6; k++) begin m_pos = 3'(k); ev(2 + 2*k, "t3_pos_up"); end
        m_open = 1'b1; m_pin = 4'b0000; ev(15, "t3_open_top");
        m_open = 1'b0; m_dir = 2'b10; ev(18, "t3_reverse");
        for (int k = 5; k >= 2; k--) begin m_pos = 3'(k); ev(20 + 2*(5 - k), "t3_pos_down"); end
        m_open = 1'b1; m_pdn = 3'b000; ev(27, "t3_open_f1");
        m_open = 1'b0; m_dir = 2'b00; ev(30, "t3_idle");
        press(1, 4'b1000, 3'b000, 3'b001);
        end_test(34);

        // T4: dwell restart at floor 1; matching up call absorbed, opposite down call latched
        start_test(1'b0);
        m_pin = 4'b0010; ev(1, "t4_latch");
        m_dir = 2'b01; ev(2, "t4_dir_up");
        m_pos = 3'd1; ev(4, "t4_pos");
        m_pos = 3'd2; ev(6, "t4_pos");
        m_open = 1'b1; m_pin = 4'b0000; ev(7, "t4_open");
        m_pdn = 3'b001; ev(10, "t4_restart");
        ev(12, "t4_still_open");
        m_open = 1'b0; m_dir = 2'b00; ev(13, "t4_close");
        m_open = 1'b1; m_pdn = 3'b000; ev(14, "t4_reopen");
        m_open = 1'b0; ev(17, "t4_close2");
        press(1, 4'b0010, 3'b000, 3'b000);
        press(10, 4'b0010, 3'b010, 3'b001);
        end_test(20);

        // T5: from idle at floor 2, up[0] and down[3] together: up first, then down to 0
        start_test(1'b0);
        m_pin = 4'b0100; ev(1, "t5_latch");
        m_dir = 2'b01; ev(2, "t5_dir_up");
        for (int k = 1; k <= 4; k++) begin m_pos = 3'(k); ev(2 + 2*k, "t5_pos"); end
        m_open = 1'b1; m_pin = 4'b0000; ev(11, "t5_open_f2");
        m_open = 1'b0; m_dir = 2'b00; ev(14, "t5_idle_f2");
        m_pup = 3'b001; m_pdn = 3'b100; ev(16, "t5_hall_latch");
        m_dir = 2'b01; ev(17, "t5_up_first");
        m_pos = 3'd5; ev(19, "t5_pos");
        m_pos = 3'd6; ev(21, "t5_pos");
        m_open = 1'b1; m_pdn = 3'b000; ev(22, "t5_open_top");
        m_open = 1'b0; m_dir = 2'b10; ev(25, "t5_reverse");
        for (int k = 5; k >= 0; k--) begin m_pos = 3'(k); ev(27 + 2*(5 - k), "t5_pos_down"); end
        m_open = 1'b1; m_pup = 3'b000; ev(38, "t5_open_f0");
        m_open = 1'b0; m_dir = 2'b00; ev(41, "t5_idle");
        press(1, 4'b0100, 3'b000, 3'b000);
        press(16, 4'b0000, 3'b001, 3'b100);
        end_test(45);

        // T6: reset mid-move at position 3
        start_test(1'b0);
        m_pin = 4'b1000; ev(1, "t6_latch");
        m_dir = 2'b01; ev(2, "t6_dir_up");
        for (int k = 1; k <= 3; k++) begin m_pos = 3'(k); ev(2 + 2*k, "t6_pos"); end
        m_pos = 3'd0; m_dir = 2'b00; m_pin = 4'b0000; ev(9, "t6_reset");
        ev(13, "t6_quiet");
        press(1, 4'b1000, 3'b000, 3'b000);
        wait_edge(8);
        reset = 1'b1;
        wait_edge(9);
        reset = 1'b0;
        end_test(16);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
